// File: rtl/imm_field_encoder.sv
// Packs a signed 32-bit immediate into a 12- or 20-bit instruction field through a
// two-stage valid/ready pipeline, flagging values that would not sign-extend back intact.
module imm_field_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Imm32,
    input  logic [1:0]       CTRL,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      Imm12,
    output logic [19:0]      Imm20,
    output logic [1:0]       CTRL_out,
    output logic             err_range,
    output logic             err_align,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [11:0] enc_imm12;
    logic [19:0] enc_imm20;
    logic        enc_range;
    logic        enc_align;

    logic        s1_valid;
    logic [11:0] s1_imm12;
    logic [19:0] s1_imm20;
    logic [1:0]  s1_ctrl;
    logic        s1_range;
    logic        s1_align;

    logic        s2_adv;
    logic        s1_adv;

    // A value fits when every bit from the field's sign position upward matches.
    always_comb begin
        enc_imm12 = '0;
        enc_imm20 = '0;
        enc_range = 1'b0;
        enc_align = 1'b0;
        case (CTRL)
            2'b00: begin
                enc_imm12 = Imm32[11:0];
                enc_range = !((&Imm32[31:11]) || !(|Imm32[31:11]));
            end
            2'b01: begin
                enc_imm12 = Imm32[12:1];
                enc_range = !((&Imm32[31:12]) || !(|Imm32[31:12]));
                enc_align = Imm32[0];
            end
            2'b10: begin
                enc_imm20 = Imm32[19:0];
                enc_range = !((&Imm32[31:19]) || !(|Imm32[31:19]));
            end
            default: begin
                enc_imm20 = Imm32[20:1];
                enc_range = !((&Imm32[31:20]) || !(|Imm32[31:20]));
                enc_align = Imm32[0];
            end
        endcase
    end

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_imm12 <= '0;
            s1_imm20 <= '0;
            s1_ctrl  <= '0;
            s1_range <= 1'b0;
            s1_align <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_imm12 <= enc_imm12;
                s1_imm20 <= enc_imm20;
                s1_ctrl  <= CTRL;
                s1_range <= enc_range;
                s1_align <= enc_align;
            end
        end
    end

    // Output stage only reloads on advance, which keeps data frozen during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Imm12     <= '0;
            Imm20     <= '0;
            CTRL_out  <= '0;
            err_range <= 1'b0;
            err_align <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                Imm12     <= s1_imm12;
                Imm20     <= s1_imm20;
                CTRL_out  <= s1_ctrl;
                err_range <= s1_range;
                err_align <= s1_align;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= '0;
        end else if (out_valid && out_ready && (err_range || err_align) &&
                     (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_ONE;
        end
    end

endmodule
